// File: rtl/uart_tx_feeder.sv
// Host-side TX word FIFO feeding a single UART transmitter. Each start request
// is held until the device, clocked in a slower domain, acknowledges by raising busy.
module uart_tx_feeder #(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 9
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   input  logic                  Enable_In,
   input  logic                  Wr_En_In,
   input  logic [DATA_WIDTH-1:0] Wr_Data_In,
   output logic                  Full_Out,
   output logic                  Empty_Out,
   output logic [ADDR_WIDTH:0]   Count_Out,
   output logic                  Overflow_Out,
   input  logic                  Overflow_Clear_In,
   output logic                  Start_Signal_Out,
   output logic [DATA_WIDTH-1:0] Data_Out,
   input  logic                  TX_Busy_In,
   output logic                  Feeder_Busy_Out
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

   state_t                  state, state_nxt;
   logic                    busy_m, busy_s;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]     count, count_nxt;
   logic                    push, pop;
   logic                    start_nxt;
   logic [DATA_WIDTH-1:0]   data_nxt;

   // TX_Busy_In comes from the UART clock domain; only busy_s is used below.
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         busy_m <= 1'b0;
         busy_s <= 1'b0;
      end else begin
         busy_m <= TX_Busy_In;
         busy_s <= busy_m;
      end
   end

   assign push = Wr_En_In & ~Full_Out;

   // NOTE: storage array has no reset; contents are unreachable until written,
   // and leaving it unreset lets it map onto plain RAM.
   always_ff @(posedge Clk_In) begin
      if (push) mem[wr_ptr] <= Wr_Data_In;
   end

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // Pointer wrap is implicit: DEPTH equals 2**ADDR_WIDTH.
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         Full_Out  <= 1'b0;
         Empty_Out <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count     <= count_nxt;
         Full_Out  <= (count_nxt == FULL_COUNT);
         Empty_Out <= (count_nxt == '0);
      end
   end

   assign Count_Out = count;

   // A dropped push outranks a same-cycle clear.
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In)                    Overflow_Out <= 1'b0;
      else if (Wr_En_In && Full_Out)   Overflow_Out <= 1'b1;
      else if (Overflow_Clear_In)      Overflow_Out <= 1'b0;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      start_nxt = Start_Signal_Out;
      data_nxt  = Data_Out;
      case (state)
         IDLE: begin
            if (Enable_In && !Empty_Out && !busy_s) begin
               pop       = 1'b1;
               data_nxt  = mem[rd_ptr];
               start_nxt = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (busy_s) begin
               start_nxt = 1'b0;
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!busy_s) state_nxt = IDLE;
         end
         default: begin
            start_nxt = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         state            <= IDLE;
         Start_Signal_Out <= 1'b0;
         Data_Out         <= '0;
      end else begin
         state            <= state_nxt;
         Start_Signal_Out <= start_nxt;
         Data_Out         <= data_nxt;
      end
   end

   assign Feeder_Busy_Out = (state != IDLE);

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Buffers 9-bit TX words from a host-side producer in a synchronous FIFO.
- Feeds one UART_Device transmitter one word at a time: drives its Start_Signal_In and Data_In, paced by its TX_Busy_Indicator.
- Sits directly upstream of a UART device, in the Clk_In domain.
- TX_Busy_In is generated in the slower TX UART clock domain, so the start request is held until the device acknowledges it by raising busy.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, 2 or more.
- ADDR_WIDTH, 4, log2(DEPTH).
- DATA_WIDTH, 9, word width; matches the maximum UART data length.

Ports:
- Clk_In  input  1  system clock; all logic on rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Enable_In  input  1  when low, no new transfer is launched; a transfer already in flight completes.
- Wr_En_In  input  1  push request.
- Wr_Data_In  input  DATA_WIDTH  word to push.
- Full_Out  output  1  FIFO full (registered).
- Empty_Out  output  1  FIFO empty (registered).
- Count_Out  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- Overflow_Out  output  1  sticky flag: a push was attempted while full.
- Overflow_Clear_In  input  1  clears Overflow_Out.
- Start_Signal_Out  output  1  to the UART device Start_Signal_In.
- Data_Out  output  DATA_WIDTH  to the UART device Data_In.
- TX_Busy_In  input  1  from the UART device TX_Busy_Indicator (asynchronous to Clk_In).
- Feeder_Busy_Out  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high) forces the following; Reset_In mid-transfer aborts immediately and the FIFO contents are discarded:
  - state = IDLE
  - read/write pointers and count = 0
  - Empty_Out = 1, Full_Out = 0, Count_Out = 0, Overflow_Out = 0
  - Start_Signal_Out = 0, Data_Out = 0, Feeder_Busy_Out = 0
  - both synchronizer flops = 0
- TX_Busy_In passes through a 2-flop synchronizer; busy_s is the second flop. The FSM uses only busy_s.
- Push rule:
  - A push is accepted when Wr_En_In=1 and Full_Out=0, sampled at the start of the cycle.
  - A push while Full_Out=1 is dropped and sets Overflow_Out on the next edge, even if a pop occurs in the same cycle.
  - Overflow_Clear_In=1 clears Overflow_Out. If a clear and a new overflow happen in the same cycle, set wins.
- Count:
  - push only: +1; pop only: -1; push and pop together: unchanged.
  - Full_Out = (count==DEPTH); Empty_Out = (count==0). Both update on the same edge as count.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if Enable_In=1, Empty_Out=0 and busy_s=0, pop the head word. On the next edge: Data_Out <= head word, Start_Signal_Out <= 1, go to REQ.
  - REQ: hold Start_Signal_Out=1 and Data_Out stable until busy_s=1. On that edge: Start_Signal_Out <= 0, go to WAIT_DONE.
  - WAIT_DONE: Data_Out is held. When busy_s=0, go to IDLE.
- Data_Out keeps its last value in IDLE; it changes only when a word is popped.
- Latency:
  - A push into an empty FIFO at edge N makes Empty_Out=0 after N.
  - With IDLE, Enable_In=1 and busy_s=0, Start_Signal_Out rises at edge N+1.
  - Minimum gap between two start launches is 1 cycle in IDLE after busy_s falls.
- Enable_In low during REQ or WAIT_DONE has no effect on that transfer.
- If busy_s is already 1 in IDLE (device busy from elsewhere), no launch occurs until it falls.
- A push in the same cycle as an IDLE pop is legal; count follows the push-and-pop rule.

Test Plan:
- Reset mid-REQ: push 0x0A5 and reach REQ, then pulse Reset_In asynchronously -> all outputs reach reset values immediately, Count_Out=0, no further Start_Signal_Out.
- Single word: push 0x1A5 into an empty FIFO, TX_Busy_In stays low for 5 cycles and then high -> Start_Signal_Out=1 with Data_Out=0x1A5 from edge N+1 until 2 cycles after busy rises; Count_Out returns to 0.
- Back-to-back: push 0x001, 0x002, 0x003; device model raises busy 3 cycles after start and drops it 20 cycles later -> exactly three start pulses, data in order 0x001, 0x002, 0x003, each launched only after busy_s has fallen.
- Full/overflow: hold busy high, Enable_In=0, push 17 words (DEPTH=16) -> Full_Out=1 after the 16th push, Count_Out=16, 17th push dropped, Overflow_Out=1; pulse Overflow_Clear_In -> Overflow_Out=0.
- Wrap-around: push and drain 40 words with an incrementing pattern -> output sequence matches exactly and Empty_Out=1 at the end.
- Enable gating: FIFO holds 2 words, Enable_In=0 -> no start; drop Enable_In during WAIT_DONE of the first transfer -> that transfer completes, the second is not launched until Enable_In=1.
